// File: rtl/loop_pkg.sv
// Shared defaults, FSM state type and slice helper for the nested loop index generator.
package loop_pkg;

  localparam int unsigned DefW = 32;
  localparam int unsigned DefN = 3;

  typedef enum logic {StIdle, StRun} loop_state_e;

  // LSB position of level i inside a flattened N*W vector.
  function automatic int unsigned slice_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/loop_level.sv
// One level of the loop nest: holds its index and reports termination of the current step.
module loop_level #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic [W-1:0] ini_i,
  input  logic [W-1:0] fin_i,
  input  logic [W-1:0] step_i,
  input  logic         carry_i,
  input  logic         fire_i,
  input  logic         idle_i,
  output logic [W-1:0] data_o,
  output logic         term_o,
  output logic         carry_o
);

  logic [W-1:0] data_q, data_d;
  logic [W:0]   sum;

  // One extra bit so an increment past the top of the range still terminates.
  assign sum     = {1'b0, data_q} + {1'b0, step_i};
  assign term_o  = (step_i == '0) || (sum > {1'b0, fin_i});
  assign carry_o = carry_i & term_o;
  assign data_o  = data_q;

  always_comb begin
    data_d = data_q;
    if (idle_i) begin
      data_d = ini_i;
    end else if (fire_i && carry_i) begin
      data_d = term_o ? ini_i : sum[W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/loop_nest.sv
// N-level nested loop index generator; level 0 is the innermost, fastest-moving index.
module loop_nest
  import loop_pkg::*;
#(
  parameter int unsigned W = DefW,
  parameter int unsigned N = DefN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] ini,
  input  logic [N*W-1:0] fin,
  input  logic [N*W-1:0] step,
  input  logic           start,
  input  logic           en,
  output logic [N*W-1:0] data,
  output logic           next,
  output logic           last,
  output logic [N-1:0]   wrap,
  output logic           busy
);

  loop_state_e  state_q, state_d;
  logic         next_q, next_d;
  logic         active, fire, idle;
  logic [N-1:0] term, carry, carry_out;

  assign busy   = (state_q == StRun);
  assign active = busy | start;
  assign fire   = active & en;
  // Reset reloads ini exactly like an idle cycle does.
  assign idle   = rst | ~active;

  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < N; i++) begin
      carry[i] = carry[i-1] & term[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lvl
    loop_level #(
      .W(W)
    ) u_level (
      .clk_i  (clk),
      .ini_i  (ini[slice_lsb(i, W) +: W]),
      .fin_i  (fin[slice_lsb(i, W) +: W]),
      .step_i (step[slice_lsb(i, W) +: W]),
      .carry_i(carry[i]),
      .fire_i (fire),
      .idle_i (idle),
      .data_o (data[slice_lsb(i, W) +: W]),
      .term_o (term[i]),
      .carry_o(carry_out[i])
    );
  end

  assign wrap = {N{fire}} & carry_out;
  assign last = fire & carry_out[N-1];
  // A start that arrives mid-run is ignored, so it must not raise next either.
  assign next = (start & ~busy) | next_q;

  always_comb begin
    state_d = state_q;
    next_d  = fire & ~last;
    unique case (state_q)
      StIdle:  if (start && !last) state_d = StRun;
      StRun:   if (fire && last)   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      next_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
    end
  end

endmodule
